// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// Module  : hazard_stall_ctrl_if
// Brief   : Pipeline-side signal bundle for the hazard/stall controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_rs_tuse;
  logic [1:0] D_rt_tuse;
  logic       D_is_md;
  logic [4:0] E_wr_addr;
  logic [1:0] E_tnew;
  logic [4:0] M_wr_addr;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       F_pc_en;
  logic       FD_en;
  logic       DE_flush;
  logic       md_busy;
  logic       md_done;

  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    output E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_is_div,
    input  F_pc_en, FD_en, DE_flush, md_busy, md_done
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
    input  E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_is_div,
    output F_pc_en, FD_en, DE_flush, md_busy, md_done
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : D-stage hazard/stall decision plus multiply/divide busy sequencer.
//           Define HAZARD_STALL_CNT_EN to add the 32-bit stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire                   clk,
  input  wire                   reset,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  hazard_stall_ctrl_if.slave    bus
);

  localparam logic [3:0] C_MULT_CNT = MULT_CYCLES[3:0];
  localparam logic [3:0] C_DIV_CNT  = DIV_CYCLES[3:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic w_rs_stall;
  logic w_rt_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_busy;

  // A producer only blocks D when its result lands later than D needs it.
  always_comb begin
    w_rs_stall = 1'b0;
    w_rt_stall = 1'b0;
    if (bus.D_rs_addr != 5'd0) begin
      if ((bus.D_rs_addr == bus.E_wr_addr) && (bus.E_tnew > bus.D_rs_tuse))
        w_rs_stall = 1'b1;
      if ((bus.D_rs_addr == bus.M_wr_addr) && (bus.M_tnew > bus.D_rs_tuse))
        w_rs_stall = 1'b1;
    end
    if (bus.D_rt_addr != 5'd0) begin
      if ((bus.D_rt_addr == bus.E_wr_addr) && (bus.E_tnew > bus.D_rt_tuse))
        w_rt_stall = 1'b1;
      if ((bus.D_rt_addr == bus.M_wr_addr) && (bus.M_tnew > bus.D_rt_tuse))
        w_rt_stall = 1'b1;
    end
  end

  assign w_busy     = (state_q == ST_BUSY);
  assign w_md_stall = bus.D_is_md && (w_busy || bus.E_md_start);
  assign w_stall    = !reset && (w_rs_stall || w_rt_stall || w_md_stall);

  assign bus.F_pc_en  = !w_stall;
  assign bus.FD_en    = !w_stall;
  assign bus.DE_flush = w_stall;
  assign bus.md_busy  = !reset && w_busy;
  assign bus.md_done  = !reset && w_busy && (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.E_md_start) begin
          cnt_d   = bus.E_md_is_div ? C_DIV_CNT : C_MULT_CNT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A new start while busy is deliberately ignored.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= 32'd0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed self-checking bench for hazard_stall_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_stall_ctrl_if bus ();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {F_pc_en, FD_en, DE_flush, md_busy, md_done}
  logic [4:0] obs;
  assign obs = {bus.F_pc_en, bus.FD_en, bus.DE_flush, bus.md_busy, bus.md_done};

  localparam logic [4:0] C_RUN       = 5'b11000;
  localparam logic [4:0] C_STALL     = 5'b00100;
  localparam logic [4:0] C_BUSY      = 5'b11010;
  localparam logic [4:0] C_BUSY_DONE = 5'b11011;
  localparam logic [4:0] C_BUSY_STL  = 5'b00110;
  localparam logic [4:0] C_DONE_STL  = 5'b00111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.D_rs_addr   = 5'd0;
    bus.D_rt_addr   = 5'd0;
    bus.D_rs_tuse   = 2'd3;
    bus.D_rt_tuse   = 2'd3;
    bus.D_is_md     = 1'b0;
    bus.E_wr_addr   = 5'd0;
    bus.E_tnew      = 2'd0;
    bus.M_wr_addr   = 5'd0;
    bus.M_tnew      = 2'd0;
    bus.E_md_start  = 1'b0;
    bus.E_md_is_div = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    // A live hazard must not show through while reset is asserted.
    bus.E_wr_addr = 5'd8; bus.E_tnew = 2'd2;
    bus.D_rs_addr = 5'd8; bus.D_rs_tuse = 2'd1;
    step();
    step();
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs, C_RUN);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== C_STALL) begin
      n_err++;
      $display("FAIL post_reset_hazard: got %b want %b", obs, C_STALL);
    end
    drive_idle();
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b want %b", obs, C_RUN);
    end
  endtask

  task automatic test_data_hazard();
    drive_idle();
    bus.E_wr_addr = 5'd8; bus.E_tnew = 2'd2;
    bus.D_rs_addr = 5'd8; bus.D_rs_tuse = 2'd1;
    #1;
    n_cmp++;
    if (obs !== C_STALL) begin
      n_err++;
      $display("FAIL load_use_e: got %b want %b", obs, C_STALL);
    end
    bus.E_tnew = 2'd0;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL load_use_resolved: got %b want %b", obs, C_RUN);
    end
    drive_idle();
    bus.M_wr_addr = 5'd9; bus.M_tnew = 2'd1;
    bus.D_rt_addr = 5'd9; bus.D_rt_tuse = 2'd0;
    #1;
    n_cmp++;
    if (obs !== C_STALL) begin
      n_err++;
      $display("FAIL rt_vs_m: got %b want %b", obs, C_STALL);
    end
    bus.D_rt_tuse = 2'd1;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL rt_tnew_eq_tuse: got %b want %b", obs, C_RUN);
    end
    drive_idle();
    bus.E_wr_addr = 5'd5; bus.E_tnew = 2'd3;
    bus.D_rs_addr = 5'd5; bus.D_rs_tuse = 2'd3;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL tuse_never: got %b want %b", obs, C_RUN);
    end
    drive_idle();
    bus.E_wr_addr = 5'd4; bus.E_tnew = 2'd1;
    bus.D_rt_addr = 5'd4; bus.D_rt_tuse = 2'd0;
    bus.D_rs_addr = 5'd7; bus.D_rs_tuse = 2'd2;
    #1;
    n_cmp++;
    if (obs !== C_STALL) begin
      n_err++;
      $display("FAIL rt_vs_e: got %b want %b", obs, C_STALL);
    end
    drive_idle();
    #1;
  endtask

  task automatic test_zero_reg();
    drive_idle();
    bus.D_rt_addr = 5'd0; bus.D_rt_tuse = 2'd0;
    bus.E_wr_addr = 5'd0; bus.E_tnew = 2'd2;
    bus.D_rs_addr = 5'd0; bus.D_rs_tuse = 2'd0;
    bus.M_wr_addr = 5'd0; bus.M_tnew = 2'd3;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL zero_reg: got %b want %b", obs, C_RUN);
    end
    drive_idle();
    #1;
  endtask

  task automatic test_mult();
    drive_idle();
    bus.D_is_md    = 1'b1;
    bus.E_md_start = 1'b1;
    bus.E_md_is_div = 1'b0;
    #1;
    n_cmp++;
    if (obs !== C_STALL) begin
      n_err++;
      $display("FAIL mult_start_cycle: got %b want %b", obs, C_STALL);
    end
    step();
    bus.E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++;
      if (obs !== ((k < 5) ? C_BUSY_STL : C_DONE_STL)) begin
        n_err++;
        $display("FAIL mult_busy_%0d: got %b want %b", k, obs,
                 (k < 5) ? C_BUSY_STL : C_DONE_STL);
      end
      step();
    end
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL mult_after: got %b want %b", obs, C_RUN);
    end
    drive_idle();
  endtask

  task automatic test_div();
    drive_idle();
    bus.E_md_start  = 1'b1;
    bus.E_md_is_div = 1'b1;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL div_start_no_md: got %b want %b", obs, C_RUN);
    end
    step();
    bus.E_md_start  = 1'b0;
    bus.E_md_is_div = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      // A spurious start in busy cycle 3 must not reload the counter.
      bus.E_md_start = (k == 3);
      #1;
      n_cmp++;
      if (obs !== ((k < 10) ? C_BUSY : C_BUSY_DONE)) begin
        n_err++;
        $display("FAIL div_busy_%0d: got %b want %b", k, obs,
                 (k < 10) ? C_BUSY : C_BUSY_DONE);
      end
      step();
    end
    bus.E_md_start = 1'b0;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL div_after: got %b want %b", obs, C_RUN);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    bus.E_md_start = 1'b1;
    step();
    bus.E_md_start = 1'b0;
    // Data and MDU stall together still look like one stall.
    bus.D_is_md   = 1'b1;
    bus.E_wr_addr = 5'd3; bus.E_tnew = 2'd2;
    bus.D_rs_addr = 5'd3; bus.D_rs_tuse = 2'd0;
    #1;
    n_cmp++;
    if (obs !== C_BUSY_STL) begin
      n_err++;
      $display("FAIL dual_stall: got %b want %b", obs, C_BUSY_STL);
    end
    drive_idle();
    for (int k = 1; k <= 5; k++) step();
    // Restart immediately in the first idle cycle.
    bus.E_md_start  = 1'b1;
    bus.E_md_is_div = 1'b0;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL b2b_idle: got %b want %b", obs, C_RUN);
    end
    step();
    bus.E_md_start = 1'b0;
    #1;
    n_cmp++;
    if (obs !== C_BUSY) begin
      n_err++;
      $display("FAIL b2b_restart: got %b want %b", obs, C_BUSY);
    end
    for (int k = 1; k <= 5; k++) step();
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL b2b_after: got %b want %b", obs, C_RUN);
    end
  endtask

  task automatic test_reset_mid_div();
    drive_idle();
    bus.E_md_start  = 1'b1;
    bus.E_md_is_div = 1'b1;
    step();
    drive_idle();
    for (int k = 1; k < 4; k++) step();
    #1;
    n_cmp++;
    if (obs !== C_BUSY) begin
      n_err++;
      $display("FAIL div_cycle4: got %b want %b", obs, C_BUSY);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== C_RUN) begin
      n_err++;
      $display("FAIL reset_gates_busy: got %b want %b", obs, C_RUN);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      n_cmp++;
      if (obs !== C_RUN) begin
        n_err++;
        $display("FAIL after_mid_reset_%0d: got %b want %b", k, obs, C_RUN);
      end
      step();
    end
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL stall_cnt_reset: got %0d want 0", stall_cnt);
    end
    bus.E_wr_addr = 5'd8; bus.E_tnew = 2'd2;
    bus.D_rs_addr = 5'd8; bus.D_rs_tuse = 2'd1;
    for (int k = 0; k < 7; k++) step();
    drive_idle();
    step();
    step();
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_err++;
      $display("FAIL stall_cnt_7: got %0d want 7", stall_cnt);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_data_hazard();
    test_zero_reg();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
